// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and constants for the icache/dcache memory-port arbiter.
package cache_mem_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W = 64;
  localparam int unsigned DEF_LINE_W = 128;

  // Requester indices, also used as the round-robin last-grant pointer value
  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_I = 2'd1,
    ST_GNT_D = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bundle of both cache request ports plus the shared memory port.
interface cache_mem_arbiter_if import cache_mem_arbiter_pkg::*; #(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned LINE_W = DEF_LINE_W
) ();

  logic [ADDR_W-1:0] i_addr_i;
  logic              i_req_i;
  logic              i_valid_i;
  logic [LINE_W-1:0] i_wdata_i;
  logic [LINE_W-1:0] i_rdata_o;
  logic              i_ready_o;

  logic [ADDR_W-1:0] d_addr_i;
  logic              d_req_i;
  logic              d_valid_i;
  logic [LINE_W-1:0] d_wdata_i;
  logic [LINE_W-1:0] d_rdata_o;
  logic              d_ready_o;

  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_req_o;
  logic              mem_valid_o;
  logic [LINE_W-1:0] mem_wdata_o;
  logic [LINE_W-1:0] mem_rdata_i;
  logic              mem_ready_i;

  logic [1:0]        grant_o;
  logic              busy_o;

  // Arbiter side
  modport slave (
    input  i_addr_i, i_req_i, i_valid_i, i_wdata_i,
    input  d_addr_i, d_req_i, d_valid_i, d_wdata_i,
    input  mem_rdata_i, mem_ready_i,
    output i_rdata_o, i_ready_o, d_rdata_o, d_ready_o,
    output mem_addr_o, mem_req_o, mem_valid_o, mem_wdata_o,
    output grant_o, busy_o
  );

  // Caches and memory bridge side
  modport master (
    output i_addr_i, i_req_i, i_valid_i, i_wdata_i,
    output d_addr_i, d_req_i, d_valid_i, d_wdata_i,
    output mem_rdata_i, mem_ready_i,
    input  i_rdata_o, i_ready_o, d_rdata_o, d_ready_o,
    input  mem_addr_o, mem_req_o, mem_valid_o, mem_wdata_o,
    input  grant_o, busy_o
  );

endinterface

// File: rtl/cache_mem_arbiter_rr_arbiter2.sv
// Two-way arbiter: round-robin on a last-grant pointer, or fixed D priority.
module cache_mem_arbiter_rr_arbiter2 import cache_mem_arbiter_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,      // {D,I}
  input  logic       rr_mode_i,
  input  logic       upd_i,
  input  logic       upd_idx_i,
  output logic [1:0] gnt_c_o     // {D,I} one-hot, combinational
);

  logic last_q;
  logic last_d;

  assign last_d = upd_i ? upd_idx_i : last_q;

  // Pointer starts at I so D wins the first tie
  always_ff @(posedge clk) begin
    if (rst) last_q <= REQ_I;
    else     last_q <= last_d;
  end

  always_comb begin
    gnt_c_o = 2'b00;
    case (req_i)
      2'b01:   gnt_c_o = 2'b01;
      2'b10:   gnt_c_o = 2'b10;
      2'b11:   gnt_c_o = (rr_mode_i && (last_q == REQ_D)) ? 2'b01 : 2'b10;
      default: gnt_c_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one line-wide memory port between icache and dcache, one transaction at a time.
module cache_mem_arbiter import cache_mem_arbiter_pkg::*; #(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned LINE_W  = DEF_LINE_W,
  parameter bit          RR_MODE = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  cache_mem_arbiter_if.slave bus
);

  state_e            state_q, state_d;
  logic [1:0]        arb_gnt;
  logic              last_upd;
  logic              last_idx;

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_valid_q, mem_valid_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_ready_q, i_ready_d;
  logic              d_ready_q, d_ready_d;
  logic [1:0]        grant_q, grant_d;
  logic              busy_q, busy_d;

  cache_mem_arbiter_rr_arbiter2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     ({bus.d_valid_i, bus.i_valid_i}),
    .rr_mode_i (RR_MODE),
    .upd_i     (last_upd),
    .upd_idx_i (last_idx),
    .gnt_c_o   (arb_gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_gnt[REQ_D])      state_d = ST_GNT_D;
        else if (arb_gnt[REQ_I]) state_d = ST_GNT_I;
      end
      ST_GNT_I, ST_GNT_D: if (bus.mem_ready_i) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Latch winner on grant, capture response on completion; mem_ready_i outside GNT_x is ignored
  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_req_d   = mem_req_q;
    mem_valid_d = mem_valid_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    last_upd    = 1'b0;
    last_idx    = REQ_I;
    case (state_q)
      ST_IDLE: begin
        if (arb_gnt[REQ_D]) begin
          mem_valid_d = 1'b1;
          mem_addr_d  = bus.d_addr_i;
          mem_req_d   = bus.d_req_i;
          mem_wdata_d = bus.d_wdata_i;
        end else if (arb_gnt[REQ_I]) begin
          mem_valid_d = 1'b1;
          mem_addr_d  = bus.i_addr_i;
          mem_req_d   = bus.i_req_i;
          mem_wdata_d = bus.i_wdata_i;
        end
      end
      ST_GNT_I: begin
        if (bus.mem_ready_i) begin
          mem_valid_d = 1'b0;
          i_rdata_d   = bus.mem_rdata_i;
          i_ready_d   = 1'b1;
          last_upd    = 1'b1;
          last_idx    = REQ_I;
        end
      end
      ST_GNT_D: begin
        if (bus.mem_ready_i) begin
          mem_valid_d = 1'b0;
          d_rdata_d   = bus.mem_rdata_i;
          d_ready_d   = 1'b1;
          last_upd    = 1'b1;
          last_idx    = REQ_D;
        end
      end
      default: ;
    endcase
    grant_d = (state_d == ST_GNT_I) ? 2'b01 :
              (state_d == ST_GNT_D) ? 2'b10 : 2'b00;
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      grant_q     <= 2'b00;
      busy_q      <= 1'b0;
    end else begin
      mem_addr_q  <= mem_addr_d;
      mem_req_q   <= mem_req_d;
      mem_valid_q <= mem_valid_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_valid_o = mem_valid_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.i_rdata_o   = i_rdata_q;
  assign bus.d_rdata_o   = d_rdata_q;
  assign bus.i_ready_o   = i_ready_q;
  assign bus.d_ready_o   = d_ready_q;
  assign bus.grant_o     = grant_q;
  assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench: round-robin and fixed-priority arbiters fed by directed vectors.
module tb_cache_mem_arbiter;
  import cache_mem_arbiter_pkg::*;

  localparam int unsigned AW  = DEF_ADDR_W;
  localparam int unsigned LW  = DEF_LINE_W;
  localparam int          LAT = 3;

  typedef struct packed {
    logic          own_d;
    logic [AW-1:0] addr;
    logic          req;
    logic [LW-1:0] wdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) rr_if ();
  cache_mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) fp_if ();

  cache_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .RR_MODE(1'b1)) u_rr (
    .clk (clk), .rst (rst), .bus (rr_if.slave));
  cache_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .RR_MODE(1'b0)) u_fp (
    .clk (clk), .rst (rst), .bus (fp_if.slave));

  int checks   = 0;
  int failures = 0;

  exp_t sb0 [$];
  exp_t sb1 [$];
  int            rd_idx    [2] = '{0, 0};
  int            pulse_cnt [2] = '{0, 0};
  int            gap       [2] = '{0, 0};
  bit            seen_fall [2] = '{0, 0};
  logic          prev_mv   [2] = '{1'b0, 1'b0};
  logic          prev_rdy  [2] = '{1'b0, 1'b0};
  logic [LW-1:0] mdl_rd    [2][2];
  bit            mdl_vld   [2][2];
  int            cnt       [2] = '{0, 0};
  int            stray_req  = 0;
  int            stray_done = 0;

  function automatic logic [LW-1:0] mem_fn(input logic [AW-1:0] a);
    return {a ^ 64'hA5A5_0000_0000_0000, 64'h0123_4567_DEAD_BEEF};
  endfunction

  function automatic void sb_push(input bit k, input exp_t e);
    if (k) sb1.push_back(e);
    else   sb0.push_back(e);
  endfunction

  function automatic int sb_size(input bit k);
    if (k) return sb1.size();
    return sb0.size();
  endfunction

  function automatic exp_t sb_get(input bit k, input int i);
    if (k) return sb1[i];
    return sb0[i];
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Memory model: completes each request LAT cycles after mem_valid_o, plus optional stray pulse
  task automatic resp_step(input bit k, input logic mv, input logic [AW-1:0] maddr,
                           output logic rdy, output logic [LW-1:0] rd);
    rdy = 1'b0;
    rd  = '0;
    if (rst || !mv) cnt[k] = 0;
    else begin
      cnt[k]++;
      if (cnt[k] == LAT) begin
        rdy = 1'b1;
        rd  = mem_fn(maddr);
      end
    end
  endtask

  initial begin : responder
    logic          r;
    logic [LW-1:0] d;
    rr_if.mem_ready_i = 1'b0;
    rr_if.mem_rdata_i = '0;
    fp_if.mem_ready_i = 1'b0;
    fp_if.mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      resp_step(1'b0, rr_if.mem_valid_o, rr_if.mem_addr_o, r, d);
      if (stray_req != stray_done && !rr_if.mem_valid_o && !rst) begin
        r = 1'b1;
        d = '1;
        stray_done++;
      end
      rr_if.mem_ready_i = r;
      rr_if.mem_rdata_i = d;
      resp_step(1'b1, fp_if.mem_valid_o, fp_if.mem_addr_o, r, d);
      fp_if.mem_ready_i = r;
      fp_if.mem_rdata_i = d;
    end
  end

  task automatic mon_step(input bit k, input logic i_rdy, input logic d_rdy,
                          input logic [LW-1:0] i_rd, input logic [LW-1:0] d_rd,
                          input logic mv, input logic [AW-1:0] maddr, input logic mreq,
                          input logic [LW-1:0] mwd, input logic [1:0] gnt);
    exp_t e;
    if (rst) begin
      rd_idx[k] = sb_size(k);
      prev_mv[k] = 1'b0; prev_rdy[k] = 1'b0;
      seen_fall[k] = 1'b0; gap[k] = 0;
      mdl_vld[k][0] = 1'b0; mdl_vld[k][1] = 1'b0;
      return;
    end
    if (mv && !prev_mv[k]) begin
      if (seen_fall[k]) begin
        checks++;
        if (gap[k] < 2) begin
          failures++;
          $display("FAIL inst%0d_bubble idle_cycles=%0d required>=2", k, gap[k]);
        end
      end
      if (rd_idx[k] >= sb_size(k)) begin
        checks++; failures++;
        $display("FAIL inst%0d_unexpected_grant addr=%0h required=none", k, maddr);
      end else begin
        e = sb_get(k, rd_idx[k]);
        chk($sformatf("inst%0d_grant", k), LW'(gnt), LW'(e.own_d ? 2'b10 : 2'b01));
        chk($sformatf("inst%0d_mem_addr", k), LW'(maddr), LW'(e.addr));
        chk($sformatf("inst%0d_mem_req", k), LW'(mreq), LW'(e.req));
        chk($sformatf("inst%0d_mem_wdata", k), mwd, e.wdata);
      end
    end
    if (!mv && prev_mv[k]) begin
      seen_fall[k] = 1'b1;
      gap[k] = 0;
    end
    if (!mv) gap[k]++;
    if (i_rdy || d_rdy) begin
      pulse_cnt[k]++;
      chk($sformatf("inst%0d_both_ready", k), LW'(i_rdy & d_rdy), '0);
      chk($sformatf("inst%0d_ready_width", k), LW'(prev_rdy[k]), '0);
      if (rd_idx[k] >= sb_size(k)) begin
        checks++; failures++;
        $display("FAIL inst%0d_unexpected_ready i=%0b d=%0b required=none", k, i_rdy, d_rdy);
      end else begin
        e = sb_get(k, rd_idx[k]);
        chk($sformatf("inst%0d_ready_owner", k), LW'(d_rdy), LW'(e.own_d));
        chk($sformatf("inst%0d_held_addr", k), LW'(maddr), LW'(e.addr));
        mdl_rd[k][e.own_d]  = mem_fn(e.addr);
        mdl_vld[k][e.own_d] = 1'b1;
        rd_idx[k]++;
      end
      if (mdl_vld[k][0]) chk($sformatf("inst%0d_i_rdata", k), i_rd, mdl_rd[k][0]);
      if (mdl_vld[k][1]) chk($sformatf("inst%0d_d_rdata", k), d_rd, mdl_rd[k][1]);
    end
    prev_rdy[k] = i_rdy | d_rdy;
    prev_mv[k]  = mv;
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      mon_step(1'b0, rr_if.i_ready_o, rr_if.d_ready_o, rr_if.i_rdata_o, rr_if.d_rdata_o,
               rr_if.mem_valid_o, rr_if.mem_addr_o, rr_if.mem_req_o, rr_if.mem_wdata_o,
               rr_if.grant_o);
      mon_step(1'b1, fp_if.i_ready_o, fp_if.d_ready_o, fp_if.i_rdata_o, fp_if.d_rdata_o,
               fp_if.mem_valid_o, fp_if.mem_addr_o, fp_if.mem_req_o, fp_if.mem_wdata_o,
               fp_if.grant_o);
    end
  end

  task automatic wait_drain(input bit k, input int budget);
    int n = 0;
    while (rd_idx[k] < sb_size(k) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rd_idx[k] < sb_size(k)) begin
      failures++;
      $display("FAIL inst%0d_drain_timeout pending=%0d required=0", k, sb_size(k) - rd_idx[k]);
    end
  endtask

  initial begin : stim
    int p;
    rst = 1'b1;
    rr_if.i_valid_i = 1'b0; rr_if.i_addr_i = '0; rr_if.i_req_i = 1'b0; rr_if.i_wdata_i = '0;
    rr_if.d_valid_i = 1'b0; rr_if.d_addr_i = '0; rr_if.d_req_i = 1'b0; rr_if.d_wdata_i = '0;
    fp_if.i_valid_i = 1'b0; fp_if.i_addr_i = '0; fp_if.i_req_i = 1'b0; fp_if.i_wdata_i = '0;
    fp_if.d_valid_i = 1'b0; fp_if.d_addr_i = '0; fp_if.d_req_i = 1'b0; fp_if.d_wdata_i = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_mem_valid", LW'(rr_if.mem_valid_o), '0);
    chk("rst_mem_req",   LW'(rr_if.mem_req_o), '0);
    chk("rst_i_ready",   LW'(rr_if.i_ready_o), '0);
    chk("rst_d_ready",   LW'(rr_if.d_ready_o), '0);
    chk("rst_grant",     LW'(rr_if.grant_o), '0);
    chk("rst_busy",      LW'(rr_if.busy_o), '0);
    chk("rst_mem_addr",  LW'(rr_if.mem_addr_o), '0);
    chk("rst_mem_wdata", rr_if.mem_wdata_o, '0);
    chk("rst_fp_busy",   LW'(fp_if.busy_o), '0);
    rst = 1'b0;
    @(negedge clk);

    // Single icache read, one-cycle latency to mem_valid_o
    sb_push(1'b0, '{own_d: 1'b0, addr: 64'h8000_0000, req: 1'b0, wdata: '0});
    rr_if.i_addr_i = 64'h8000_0000; rr_if.i_req_i = 1'b0; rr_if.i_valid_i = 1'b1;
    @(negedge clk);
    chk("t1_mem_valid", LW'(rr_if.mem_valid_o), LW'(1'b1));
    chk("t1_busy",      LW'(rr_if.busy_o), LW'(1'b1));
    chk("t1_grant",     LW'(rr_if.grant_o), LW'(2'b01));
    wait_drain(1'b0, 50);
    rr_if.i_valid_i = 1'b0;
    repeat (2) @(negedge clk);

    // Both held valid: D first after reset pointer, then strict alternation
    rr_if.i_addr_i = 64'h8000_0040; rr_if.i_req_i = 1'b0; rr_if.i_wdata_i = '0;
    rr_if.d_addr_i = 64'h8000_1000; rr_if.d_req_i = 1'b1; rr_if.d_wdata_i = {32{4'h5}};
    for (int r = 0; r < 3; r++) begin
      sb_push(1'b0, '{own_d: 1'b1, addr: 64'h8000_1000, req: 1'b1, wdata: {32{4'h5}}});
      sb_push(1'b0, '{own_d: 1'b0, addr: 64'h8000_0040, req: 1'b0, wdata: '0});
    end
    rr_if.i_valid_i = 1'b1; rr_if.d_valid_i = 1'b1;
    wait_drain(1'b0, 200);
    rr_if.i_valid_i = 1'b0; rr_if.d_valid_i = 1'b0;
    repeat (2) @(negedge clk);

    // Requester address changes after grant; latched address must hold
    sb_push(1'b0, '{own_d: 1'b0, addr: 64'h8000_0000, req: 1'b0, wdata: '0});
    rr_if.i_addr_i = 64'h8000_0000; rr_if.i_valid_i = 1'b1;
    @(negedge clk);
    rr_if.i_addr_i = '0;
    repeat (2) @(negedge clk);
    chk("t4_addr_held", LW'(rr_if.mem_addr_o), LW'(64'h8000_0000));
    wait_drain(1'b0, 50);
    rr_if.i_valid_i = 1'b0;
    repeat (2) @(negedge clk);

    // Stray mem_ready_i while idle
    p = pulse_cnt[0];
    stray_req++;
    repeat (5) @(negedge clk);
    chk("t6_stray_pulses", LW'(pulse_cnt[0]), LW'(p));
    chk("t6_stray_busy",   LW'(rr_if.busy_o), '0);

    // Requester drops valid mid-transaction: still exactly one owner pulse
    p = pulse_cnt[0];
    sb_push(1'b0, '{own_d: 1'b0, addr: 64'h8000_0200, req: 1'b0, wdata: '0});
    rr_if.i_addr_i = 64'h8000_0200; rr_if.i_valid_i = 1'b1;
    @(negedge clk);
    rr_if.i_valid_i = 1'b0;
    wait_drain(1'b0, 50);
    repeat (4) @(negedge clk);
    chk("t6_drop_pulses", LW'(pulse_cnt[0]), LW'(p + 1));

    // Fixed priority: D keeps winning while held, I only after D drops
    fp_if.i_addr_i = 64'h8000_0100; fp_if.i_req_i = 1'b0; fp_if.i_wdata_i = '0;
    fp_if.d_addr_i = 64'h8000_2000; fp_if.d_req_i = 1'b1; fp_if.d_wdata_i = {32{4'hA}};
    for (int r = 0; r < 3; r++)
      sb_push(1'b1, '{own_d: 1'b1, addr: 64'h8000_2000, req: 1'b1, wdata: {32{4'hA}}});
    fp_if.i_valid_i = 1'b1; fp_if.d_valid_i = 1'b1;
    wait_drain(1'b1, 200);
    fp_if.d_valid_i = 1'b0;
    sb_push(1'b1, '{own_d: 1'b0, addr: 64'h8000_0100, req: 1'b0, wdata: '0});
    wait_drain(1'b1, 50);
    fp_if.i_valid_i = 1'b0;
    repeat (2) @(negedge clk);

    // Reset while in GNT_D
    p = pulse_cnt[1];
    sb_push(1'b1, '{own_d: 1'b1, addr: 64'h8000_3000, req: 1'b1, wdata: {32{4'hA}}});
    fp_if.d_addr_i = 64'h8000_3000; fp_if.d_valid_i = 1'b1;
    @(negedge clk);
    chk("t5_in_gnt_d", LW'(fp_if.grant_o), LW'(2'b10));
    @(negedge clk);
    rst = 1'b1;
    fp_if.d_valid_i = 1'b0;
    @(negedge clk);
    chk("t5_mem_valid", LW'(fp_if.mem_valid_o), '0);
    chk("t5_grant",     LW'(fp_if.grant_o), '0);
    chk("t5_busy",      LW'(fp_if.busy_o), '0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("t5_no_pulse",  LW'(pulse_cnt[1]), LW'(p));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #100000;
    failures++;
    $display("FAIL watchdog simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
